mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 4, cycles spent on each MUX channel (legal range 2..255).
REQ-002 SHALL have parameter SETTLE, default 1, cycle index within a dwell at which MUX_out is captured (legal range 0..DWELL-1).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin scanning; sampled only in IDLE.
REQ-006 SHALL have port cont  input  1  continuous mode when 1 (sampled with start); single frame when 0.
REQ-007 SHALL have port stop  input  1  request end of scanning after the current frame.
REQ-008 SHALL have port MUX_en  output  1  enable to the downstream 2:1 mux.
REQ-009 SHALL have port MUX_sel  output  1  channel select to the 2:1 mux.
REQ-010 SHALL have port MUX_out  input  1  returned mux output being sampled.
REQ-011 SHALL have port frame_data  output  2  captured frame; bit n = MUX_out sampled while MUX_sel = n.
REQ-012 SHALL have port frame_valid  output  1  frame_data is valid.
REQ-013 SHALL have port frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port frame_cnt  output  8  count of accepted frames.

Function
REQ-016 SHALL implement FSM states IDLE, SEL0, SEL1, PRESENT; all outputs registered.
REQ-017 SHALL move IDLE -> SEL0 on the edge where start = 1; cont latched into a mode register on that edge.
REQ-018 SHALL clear an internal dwell counter on every state entry and increment it by 1 each cycle in SEL0/SEL1.
REQ-019 SHALL drive MUX_en = 1 in SEL0 and SEL1, 0 in IDLE and PRESENT.
REQ-020 SHALL drive MUX_sel = 1 only in SEL1, 0 otherwise.
REQ-021 SHALL capture MUX_out into frame_data[0] (SEL0) or frame_data[1] (SEL1) on the edge where the dwell counter = SETTLE; other frame_data bit unchanged.
REQ-022 SHALL move SEL0 -> SEL1 and SEL1 -> PRESENT on the edge where the dwell counter = DWELL-1.
REQ-023 SHALL assert frame_valid exactly while in PRESENT and hold frame_data stable there.
REQ-024 SHALL complete a handshake on an edge with frame_valid = 1 and frame_ready = 1; frame_cnt increments by 1, wrapping 255 -> 0.
REQ-025 SHALL on handshake go PRESENT -> SEL0 if mode = continuous and no stop is pending, else PRESENT -> IDLE.
REQ-026 SHALL set a stop_pending flag when stop = 1 in SEL0, SEL1 or PRESENT (including the handshake edge); flag cleared on entry to IDLE.
REQ-027 SHALL never abort a frame on stop; the current frame is always captured and presented.
REQ-028 SHALL ignore start while busy = 1; stop in IDLE has no effect.
REQ-029 SHALL give latency: start on edge 0 -> MUX_en high after edges 0..2*DWELL-1, frame_valid high after edge 2*DWELL.
REQ-030 SHALL hold PRESENT indefinitely while frame_ready = 0 (back-pressure); no mux activity during that time.

Reset
REQ-031 SHALL, on any rising edge with rst_n = 0, enter IDLE and set MUX_en = 0, MUX_sel = 0, frame_data = 0, frame_valid = 0, busy = 0, frame_cnt = 0, mode = 0, stop_pending = 0, dwell counter = 0.
REQ-032 SHALL treat reset mid-frame identically: partial frame discarded, no frame_valid pulse, frame_cnt not incremented.

Verification
REQ-033 SHALL cover single frame: defaults, cont = 0, MUX_out = 1 in SEL0 and 0 in SEL1, start pulse on edge 0, frame_ready = 1 -> MUX_en high 8 cycles, MUX_sel 0 for 4 then 1 for 4, frame_valid for 1 cycle with frame_data = 2'b01, frame_cnt = 1, back to IDLE.
REQ-034 SHALL cover back-pressure: frame_ready = 0 for 10 cycles in PRESENT -> frame_valid and frame_data held 10 cycles, MUX_en = 0, frame_cnt unchanged until ready.
REQ-035 SHALL cover continuous mode: cont = 1, 3 frames with stop pulsed during the third frame's SEL1 -> exactly 3 handshakes, frame_cnt = 3, then IDLE, busy = 0.
REQ-036 SHALL cover reset mid-operation: rst_n = 0 for 1 cycle during SEL1 -> next cycle all outputs per REQ-031, no frame_valid.
REQ-037 SHALL cover start while busy and frame_cnt wrap: start pulses during SEL0 ignored; 256 accepted frames -> frame_cnt = 0.
REQ-038 SHALL cover SETTLE boundary: SETTLE = DWELL-1 = 3, MUX_out toggling each cycle -> captured bits equal MUX_out value at dwell count 3 of each channel.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Frame handshake bundle between the scan controller and its consumer.
interface mux_scan_ctrl_if;
  logic [1:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans a 2:1 mux channel by channel, captures one sample per channel and
// presents the 2-bit frame over a valid/ready handshake.
module mux_scan_ctrl #(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   stop,
  output logic                   MUX_en,
  output logic                   MUX_sel,
  input  logic                   MUX_out,
  mux_scan_ctrl_if.master        frame_if,
  output logic                   busy,
  output logic [7:0]             frame_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEL0    = 2'd1,
    SEL1    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             stop_pending_q;

  // Outputs are updated together with the state so they always match it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      cnt_q                <= '0;
      mode_q               <= 1'b0;
      stop_pending_q       <= 1'b0;
      MUX_en               <= 1'b0;
      MUX_sel              <= 1'b0;
      frame_if.frame_data  <= 2'b00;
      frame_if.frame_valid <= 1'b0;
      busy                 <= 1'b0;
      frame_cnt            <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEL0;
            mode_q  <= cont;
            cnt_q   <= '0;
            MUX_en  <= 1'b1;
            MUX_sel <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SEL0: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (stop) stop_pending_q <= 1'b1;
          if (cnt_q == SETTLE_CNT) frame_if.frame_data[0] <= MUX_out;
          if (cnt_q == LAST_CNT) begin
            state_q <= SEL1;
            cnt_q   <= '0;
            MUX_sel <= 1'b1;
          end
        end
        SEL1: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (stop) stop_pending_q <= 1'b1;
          if (cnt_q == SETTLE_CNT) frame_if.frame_data[1] <= MUX_out;
          if (cnt_q == LAST_CNT) begin
            state_q              <= PRESENT;
            cnt_q                <= '0;
            MUX_en               <= 1'b0;
            MUX_sel              <= 1'b0;
            frame_if.frame_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (stop) stop_pending_q <= 1'b1;
          if (frame_if.frame_ready) begin
            frame_cnt            <= frame_cnt + CNT_W'(1);
            frame_if.frame_valid <= 1'b0;
            cnt_q                <= '0;
            // A stop arriving on the handshake edge itself also ends the run.
            if (mode_q && !stop_pending_q && !stop) begin
              state_q <= SEL0;
              MUX_en  <= 1'b1;
            end else begin
              state_q        <= IDLE;
              busy           <= 1'b0;
              stop_pending_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: directed scans push expected frames, monitors pop them on handshakes.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, stop, start_b;
  logic       ch0, ch1, tog;
  logic       a_en, a_sel, b_en, b_sel, a_busy, b_busy;
  logic [7:0] a_cnt, b_cnt;

  mux_scan_ctrl_if a_if ();
  mux_scan_ctrl_if b_if ();

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
    .MUX_en(a_en), .MUX_sel(a_sel), .MUX_out(a_sel ? ch1 : ch0),
    .frame_if(a_if), .busy(a_busy), .frame_cnt(a_cnt));

  mux_scan_ctrl #(.DWELL(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(1'b0), .stop(1'b0),
    .MUX_en(b_en), .MUX_sel(b_sel), .MUX_out(tog),
    .frame_if(b_if), .busy(b_busy), .frame_cnt(b_cnt));

  int total = 0;
  int bad   = 0;
  int hs_a  = 0;
  int hs_b  = 0;
  logic [7:0] model_cnt = 8'd0;
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt = 8'd0;
      hs_a      = 0;
    end else if (a_if.frame_valid && a_if.frame_ready) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_frame: got data %0h want none", a_if.frame_data);
      end else begin
        check("a_frame_data", 32'(a_if.frame_data), 32'(exp_a.pop_front()));
        check("a_cnt_at_hs", 32'(a_cnt), 32'(model_cnt));
        model_cnt = model_cnt + 8'd1;
      end
      hs_a++;
    end
  end

  // Monitor for the SETTLE = DWELL-1 instance.
  always @(negedge clk) begin
    if (rst_n && b_if.frame_valid && b_if.frame_ready) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_frame: got data %0h want none", b_if.frame_data);
      end else begin
        check("b_frame_data", 32'(b_if.frame_data), 32'(exp_b.pop_front()));
      end
      hs_b++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_en"},    32'(a_en), 32'd0);
    check({name, "_sel"},   32'(a_sel), 32'd0);
    check({name, "_valid"}, 32'(a_if.frame_valid), 32'd0);
    check({name, "_busy"},  32'(a_busy), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; stop = 1'b0; start_b = 1'b0;
    ch0 = 1'b0; ch1 = 1'b0; tog = 1'b0;
    a_if.frame_ready = 1'b1;
    b_if.frame_ready = 1'b1;
    tick(); tick();
    check_idle("rst");
    check("rst_data", 32'(a_if.frame_data), 32'd0);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single frame, ch0=1 ch1=0.
    ch0 = 1'b1; ch1 = 1'b0; cont = 1'b0;
    exp_a.push_back(2'b01);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("single_en_%0d", i), 32'(a_en), 32'd1);
      check($sformatf("single_sel_%0d", i), 32'(a_sel), (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("single_valid_%0d", i), 32'(a_if.frame_valid), 32'd0);
      tick();
    end
    check("single_valid", 32'(a_if.frame_valid), 32'd1);
    check("single_en_off", 32'(a_en), 32'd0);
    tick();
    check_idle("single_end");
    check("single_cnt", 32'(a_cnt), 32'd1);

    // Back-pressure for 10 cycles in PRESENT.
    ch0 = 1'b0; ch1 = 1'b1;
    a_if.frame_ready = 1'b0;
    exp_a.push_back(2'b10);
    pulse_start();
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(a_if.frame_valid), 32'd1);
      check("bp_data", 32'(a_if.frame_data), 32'h2);
      check("bp_en", 32'(a_en), 32'd0);
      check("bp_cnt", 32'(a_cnt), 32'd1);
      tick();
    end
    a_if.frame_ready = 1'b1;
    tick();
    check_idle("bp_end");
    check("bp_cnt_after", 32'(a_cnt), 32'd2);

    // Continuous mode, stop during third frame's SEL1.
    ch0 = 1'b1; ch1 = 1'b1; cont = 1'b1;
    base = hs_a;
    repeat (3) exp_a.push_back(2'b11);
    pulse_start();
    cont = 1'b0;
    n = 0;
    while (!(hs_a == base + 2 && a_sel) && n < 100) begin tick(); n++; end
    check("cont_reach_f3", 32'(n < 100), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (a_busy && n < 100) begin tick(); n++; end
    check("cont_idle_timeout", 32'(n < 100), 32'd1);
    check("cont_hs", 32'(hs_a - base), 32'd3);
    check("cont_cnt", 32'(a_cnt), 32'd5);
    repeat (12) tick();
    check_idle("cont_after");

    // Start pulses during SEL0 are ignored.
    ch0 = 1'b0; ch1 = 1'b0;
    exp_a.push_back(2'b00);
    pulse_start();
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check("busy_sel", 32'(a_sel), 32'd0);
    repeat (8) tick();
    check_idle("busy_end");
    check("busy_cnt", 32'(a_cnt), 32'd6);

    // Reset during SEL1 discards the frame.
    pulse_start();
    n = 0;
    while (!a_sel && n < 20) begin tick(); n++; end
    check("rstmid_reach_sel1", 32'(n < 20), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("rstmid");
    check("rstmid_data", 32'(a_if.frame_data), 32'd0);
    check("rstmid_cnt", 32'(a_cnt), 32'd0);
    repeat (12) tick();
    check("rstmid_no_valid", 32'(hs_a), 32'd0);

    // 256 accepted frames wrap frame_cnt to 0.
    ch0 = 1'b1; ch1 = 1'b1; cont = 1'b1;
    repeat (256) exp_a.push_back(2'b11);
    pulse_start();
    cont = 1'b0;
    n = 0;
    while (!(hs_a == 255 && a_en) && n < 3000) begin tick(); n++; end
    check("wrap_reach_last", 32'(n < 3000), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (a_busy && n < 100) begin tick(); n++; end
    check("wrap_idle_timeout", 32'(n < 100), 32'd1);
    check("wrap_hs", 32'(hs_a), 32'd256);
    check("wrap_cnt", 32'(a_cnt), 32'd0);

    // SETTLE = 3 with MUX_out toggling every cycle: both captures see 1.
    tog = 1'b1;
    exp_b.push_back(2'b11);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tog = ~tog;
      tick();
    end
    check("settle_hs", 32'(hs_b), 32'd1);
    check("settle_busy", 32'(b_busy), 32'd0);
    check("settle_cnt", 32'(b_cnt), 32'd1);

    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
